// File: rtl/oled_init_sequencer_pkg.sv
// Shared types, command bytes and step indices for the OLED init sequencer.
// Build macro OLED_CLEAR_EN inserts the display-RAM clear steps before display-on.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SEND,
    ST_ACK,
    ST_REL,
    ST_DELAY,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_CHG_PUMP    = 8'h8D;
  localparam logic [7:0] CMD_CHG_PUMP_EN = 8'h14;
  localparam logic [7:0] CMD_PRECHG      = 8'hD9;
  localparam logic [7:0] CMD_PRECHG_VAL  = 8'hF1;
  localparam logic [7:0] CMD_SEG_REMAP   = 8'hA1;
  localparam logic [7:0] CMD_COM_DIR     = 8'hC8;
  localparam logic [7:0] CMD_COM_CFG     = 8'hDA;
  localparam logic [7:0] CMD_COM_CFG_VAL = 8'h20;
  localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;

  localparam int CLEAR_BYTES = 512;

  localparam int STEP_W = 5;
  typedef logic [STEP_W-1:0] step_t;

  // Each multi-byte command is split into one step per byte.
  localparam step_t STEP_VDD_ON       = 5'd0;
  localparam step_t STEP_DISP_OFF     = 5'd1;
  localparam step_t STEP_RES_LOW      = 5'd2;
  localparam step_t STEP_RES_HIGH     = 5'd3;
  localparam step_t STEP_CHG_PUMP     = 5'd4;
  localparam step_t STEP_CHG_PUMP_EN  = 5'd5;
  localparam step_t STEP_PRECHG       = 5'd6;
  localparam step_t STEP_PRECHG_VAL   = 5'd7;
  localparam step_t STEP_VBAT_ON      = 5'd8;
  localparam step_t STEP_SEG_REMAP    = 5'd9;
  localparam step_t STEP_COM_DIR      = 5'd10;
  localparam step_t STEP_COM_CFG      = 5'd11;
  localparam step_t STEP_COM_CFG_VAL  = 5'd12;
`ifdef OLED_CLEAR_EN
  localparam step_t STEP_ADDR_MODE     = 5'd13;
  localparam step_t STEP_ADDR_MODE_VAL = 5'd14;
  localparam step_t STEP_CLEAR         = 5'd15;
  localparam step_t STEP_DISP_ON       = 5'd16;
  localparam step_t STEP_DONE          = 5'd17;
`else
  localparam step_t STEP_DISP_ON       = 5'd13;
  localparam step_t STEP_DONE          = 5'd14;
`endif

  function automatic logic is_delay_step(step_t s);
    return (s == STEP_VDD_ON) || (s == STEP_RES_LOW) ||
           (s == STEP_RES_HIGH) || (s == STEP_VBAT_ON);
  endfunction

  function automatic logic [7:0] step_byte(step_t s);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      STEP_DISP_OFF:      b = CMD_DISP_OFF;
      STEP_CHG_PUMP:      b = CMD_CHG_PUMP;
      STEP_CHG_PUMP_EN:   b = CMD_CHG_PUMP_EN;
      STEP_PRECHG:        b = CMD_PRECHG;
      STEP_PRECHG_VAL:    b = CMD_PRECHG_VAL;
      STEP_SEG_REMAP:     b = CMD_SEG_REMAP;
      STEP_COM_DIR:       b = CMD_COM_DIR;
      STEP_COM_CFG:       b = CMD_COM_CFG;
      STEP_COM_CFG_VAL:   b = CMD_COM_CFG_VAL;
`ifdef OLED_CLEAR_EN
      STEP_ADDR_MODE:     b = CMD_ADDR_MODE;
      STEP_ADDR_MODE_VAL: b = 8'h00;
      STEP_CLEAR:         b = 8'h00;
`endif
      STEP_DISP_ON:       b = CMD_DISP_ON;
      default:            b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_init_sequencer_if.sv
// Byte-load handshake between the init sequencer (master) and the SPI byte sender (slave).
interface oled_init_sequencer_if;
  logic [7:0] spi_data_out;
  logic       spi_load;
  logic       spi_done;

  modport master (output spi_data_out, output spi_load, input spi_done);
  modport slave  (input spi_data_out, input spi_load, output spi_done);
endinterface

// File: rtl/oled_init_sequencer_delay_timer.sv
// Millisecond delay timer: load arms a countdown of ms_count * MS_CYCLES clock cycles.
module oled_delay_timer #(
  parameter int MS_CYCLES = 100000,
  parameter int MAX_MS    = 100
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load,
  input  logic [$clog2(MAX_MS+1)-1:0]  ms_count,
  output logic                         expired
);

  localparam int CNT_W = $clog2(MAX_MS * MS_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      total;
  logic [CNT_W-1:0] load_value;

  // Loading N*MS-1 makes the owner see expired after exactly N*MS cycles in its wait state.
  assign total      = 32'(ms_count) * 32'(MS_CYCLES);
  assign load_value = (total == 32'd0) ? '0 : CNT_W'(total - 32'd1);
  assign expired    = (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/oled_init_sequencer.sv
// SSD1306 power-up sequencer: sequences the rails/reset pins and streams init commands to the SPI sender.
// Build macro OLED_CLEAR_EN adds horizontal addressing plus a 512-byte display clear before display-on.
module oled_init_sequencer
  import oled_pkg::*;
#(
  parameter int MS_CYCLES     = 100000,
  parameter int RES_DELAY_MS  = 1,
  parameter int VBAT_DELAY_MS = 100
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         init_done,
  oled_init_sequencer_if.master        spi,
  output logic                         oled_dc,
  output logic                         oled_res_n,
  output logic                         oled_vdd_n,
  output logic                         oled_vbat_n
);

  localparam int MAX_MS = (VBAT_DELAY_MS > RES_DELAY_MS) ? VBAT_DELAY_MS : RES_DELAY_MS;
  localparam int MS_W   = $clog2(MAX_MS + 1);

  state_t           state;
  state_t           next_state;
  step_t            step;
  logic             done_meta;
  logic             done_sync;
  logic             timer_load;
  logic [MS_W-1:0]  timer_ms;
  logic             timer_expired;
  logic             spi_load_c;
  logic [7:0]       data_q;

`ifdef OLED_CLEAR_EN
  logic [9:0]       clear_cnt;
`endif

  oled_delay_timer #(
    .MS_CYCLES (MS_CYCLES),
    .MAX_MS    (MAX_MS)
  ) u_delay_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .ms_count (timer_ms),
    .expired  (timer_expired)
  );

  // done_send comes from the sender's divided clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
    end else begin
      done_meta <= spi.spi_done;
      done_sync <= done_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_ms   = '0;
    spi_load_c = 1'b0;
    busy       = 1'b0;
    init_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_STEP;
      end
      ST_STEP: begin
        busy = 1'b1;
        if (step == STEP_DONE) begin
          next_state = ST_DONE;
        end else if (is_delay_step(step)) begin
          next_state = ST_DELAY;
          timer_load = 1'b1;
          timer_ms   = (step == STEP_VBAT_ON) ? MS_W'(VBAT_DELAY_MS) : MS_W'(RES_DELAY_MS);
        end else begin
          next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        busy       = 1'b1;
        spi_load_c = 1'b1;
        next_state = ST_ACK;
      end
      ST_ACK: begin
        busy       = 1'b1;
        spi_load_c = 1'b1;
        if (done_sync) next_state = ST_REL;
      end
      ST_REL: begin
        busy = 1'b1;
        if (!done_sync) next_state = ST_STEP;
      end
      ST_DELAY: begin
        busy = 1'b1;
        if (timer_expired) next_state = ST_STEP;
      end
      ST_DONE: begin
        init_done = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign spi.spi_load     = spi_load_c;
  assign spi.spi_data_out = data_q;

  // Pins and the outgoing byte are only updated on entry to a step, so they stay glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      step        <= STEP_VDD_ON;
      data_q      <= 8'h00;
      oled_dc     <= 1'b0;
      oled_res_n  <= 1'b1;
      oled_vdd_n  <= 1'b1;
      oled_vbat_n <= 1'b1;
`ifdef OLED_CLEAR_EN
      clear_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_STEP: begin
          if (!is_delay_step(step) && (step != STEP_DONE)) begin
            data_q <= step_byte(step);
          end
`ifdef OLED_CLEAR_EN
          oled_dc <= (step == STEP_CLEAR);
`else
          oled_dc <= 1'b0;
`endif
          case (step)
            STEP_VDD_ON:   oled_vdd_n  <= 1'b0;
            STEP_RES_LOW:  oled_res_n  <= 1'b0;
            STEP_RES_HIGH: oled_res_n  <= 1'b1;
            STEP_VBAT_ON:  oled_vbat_n <= 1'b0;
            default: ;
          endcase
        end
        ST_REL: begin
          if (!done_sync) begin
`ifdef OLED_CLEAR_EN
            // The clear step repeats itself until every display byte has gone out.
            if ((step == STEP_CLEAR) && (clear_cnt != 10'(CLEAR_BYTES - 1))) begin
              clear_cnt <= clear_cnt + 10'd1;
            end else begin
              clear_cnt <= '0;
              step      <= step + step_t'(1);
            end
`else
            step <= step + step_t'(1);
`endif
          end
        end
        ST_DELAY: begin
          if (timer_expired) step <= step + step_t'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Scoreboard bench for oled_init_sequencer with a cycle-level SPI sender model.
// Build macro OLED_CLEAR_EN must match the RTL build so the expected byte stream includes the clear.
module tb_oled_init_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic init_done;
  logic oled_dc;
  logic oled_res_n;
  logic oled_vdd_n;
  logic oled_vbat_n;

  oled_init_sequencer_if spi_bus ();

  oled_init_sequencer #(
    .MS_CYCLES     (10),
    .RES_DELAY_MS  (1),
    .VBAT_DELAY_MS (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .init_done   (init_done),
    .spi         (spi_bus),
    .oled_dc     (oled_dc),
    .oled_res_n  (oled_res_n),
    .oled_vdd_n  (oled_vdd_n),
    .oled_vbat_n (oled_vbat_n)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int load_count = 0;

  logic [8:0] exp_q[$];

  int ae_cyc, c8d_cyc, f1_cyc, a1_cyc;
  int vdd_fall, res_fall, res_rise, vbat_fall;

  always @(posedge clock) cycle++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
  endtask

  // SPI sender model: done rises after 4 loaded edges (204 when stalling on 0x14), falls 2 edges after load drops.
  int  load_cnt = 0;
  int  rel_cnt  = 0;
  bit  stall_en = 0;
  int  done_delay;
  assign done_delay = (stall_en && (spi_bus.spi_data_out == 8'h14)) ? 204 : 4;

  always @(posedge clock) begin
    if (reset) begin
      spi_bus.spi_done <= 1'b0;
      load_cnt <= 0;
      rel_cnt  <= 0;
    end else if (spi_bus.spi_load) begin
      rel_cnt <= 0;
      if (!spi_bus.spi_done) begin
        if (load_cnt + 1 >= done_delay) spi_bus.spi_done <= 1'b1;
        load_cnt <= load_cnt + 1;
      end
    end else begin
      load_cnt <= 0;
      if (spi_bus.spi_done) begin
        if (rel_cnt + 1 >= 2) spi_bus.spi_done <= 1'b0;
        rel_cnt <= rel_cnt + 1;
      end
    end
  end

  // Monitor: every new load is one byte; pop the scoreboard and record pin edge times.
  logic prev_load = 1'b0;
  logic prev_res  = 1'b1;
  logic prev_vdd  = 1'b1;
  logic prev_vbat = 1'b1;

  always @(negedge clock) begin
    logic [8:0] got;
    logic [8:0] exp;
    if (spi_bus.spi_load === 1'b1 && prev_load !== 1'b1) begin
      load_count++;
      got = {oled_dc, spi_bus.spi_data_out};
      if (exp_q.size() == 0) begin
        fail_now("unexpected_byte", 32'(got));
      end else begin
        exp = exp_q.pop_front();
        check("byte_dc", 32'(got), 32'(exp));
      end
      if (got == 9'h0AE && ae_cyc < 0)  ae_cyc  = cycle;
      if (got == 9'h08D && c8d_cyc < 0) c8d_cyc = cycle;
      if (got == 9'h0F1 && f1_cyc < 0)  f1_cyc  = cycle;
      if (got == 9'h0A1 && a1_cyc < 0)  a1_cyc  = cycle;
    end
    if (prev_vdd === 1'b1 && oled_vdd_n === 1'b0 && vdd_fall < 0)     vdd_fall  = cycle;
    if (prev_res === 1'b1 && oled_res_n === 1'b0 && res_fall < 0)     res_fall  = cycle;
    if (prev_res === 1'b0 && oled_res_n === 1'b1 && res_rise < 0)     res_rise  = cycle;
    if (prev_vbat === 1'b1 && oled_vbat_n === 1'b0 && vbat_fall < 0)  vbat_fall = cycle;
    prev_load = spi_bus.spi_load;
    prev_res  = oled_res_n;
    prev_vdd  = oled_vdd_n;
    prev_vbat = oled_vbat_n;
  end

  task automatic clear_marks();
    ae_cyc = -1; c8d_cyc = -1; f1_cyc = -1; a1_cyc = -1;
    vdd_fall = -1; res_fall = -1; res_rise = -1; vbat_fall = -1;
  endtask

  task automatic push_sequence();
    logic [7:0] seq [10];
    seq = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, seq[i]});
`ifdef OLED_CLEAR_EN
    exp_q.push_back(9'h020);
    exp_q.push_back(9'h000);
    for (int i = 0; i < 512; i++) exp_q.push_back(9'h100);
`endif
    exp_q.push_back({1'b0, seq[9]});
  endtask

  task automatic applyStimulus_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic applyStimulus_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_init_done(input int budget);
    int n = 0;
    while (init_done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (init_done !== 1'b1) fail_now("init_done_timeout", 32'(n));
  endtask

  task automatic checkOutput_done(input string tag);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    bit bad;
    int loads_before;

    reset = 1'b1;
    start = 1'b0;
    clear_marks();
    repeat (3) @(negedge clock);
    check("rst_busy",      32'(busy),                 32'd0);
    check("rst_init_done", 32'(init_done),            32'd0);
    check("rst_data",      32'(spi_bus.spi_data_out), 32'h00);
    check("rst_load",      32'(spi_bus.spi_load),     32'd0);
    check("rst_dc",        32'(oled_dc),              32'd0);
    check("rst_res_n",     32'(oled_res_n),           32'd1);
    check("rst_vdd_n",     32'(oled_vdd_n),           32'd1);
    check("rst_vbat_n",    32'(oled_vbat_n),          32'd1);
    reset = 1'b0;

    $display("[TB] run 1: full sequence and pin ordering");
    clear_marks();
    push_sequence();
    applyStimulus_start();
    wait_init_done(20000);
    checkOutput_done("run1");
    check("vdd_before_first_byte", 32'(vdd_fall >= 0 && ae_cyc >= 0 && vdd_fall < ae_cyc), 32'd1);
    check("res_low_after_ae",      32'(res_fall > ae_cyc && ae_cyc >= 0), 32'd1);
    check("res_low_width",         32'(res_rise - res_fall >= 10 && res_fall >= 0), 32'd1);
    check("res_high_before_8d",    32'(res_rise >= 0 && res_rise < c8d_cyc), 32'd1);
    check("vbat_after_f1",         32'(vbat_fall > f1_cyc && f1_cyc >= 0), 32'd1);
    check("vbat_before_a1_gap",    32'(a1_cyc - vbat_fall >= 30 && vbat_fall >= 0), 32'd1);

    $display("[TB] start held after done");
    loads_before = load_count;
    bad = 0;
    @(negedge clock);
    start = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (init_done !== 1'b1) bad = 1;
    end
    start = 1'b0;
    check("no_loads_after_done", 32'(load_count - loads_before), 32'd0);
    check("init_done_held",      32'(bad), 32'd0);

    $display("[TB] run 2: sender stalls on 0x14");
    applyStimulus_reset();
    push_sequence();
    stall_en = 1;
    applyStimulus_start();
    n = 0;
    while (!(spi_bus.spi_load === 1'b1 && spi_bus.spi_data_out === 8'h14) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) fail_now("stall_byte_timeout", 32'(n));
    bad = 0;
    repeat (190) begin
      @(negedge clock);
      if (spi_bus.spi_load !== 1'b1 || spi_bus.spi_data_out !== 8'h14) bad = 1;
    end
    check("stall_load_data_held", 32'(bad), 32'd0);
    wait_init_done(20000);
    stall_en = 0;
    checkOutput_done("run2");

    $display("[TB] run 3: reset during VBAT delay, then replay");
    applyStimulus_reset();
    push_sequence();
    applyStimulus_start();
    n = 0;
    while (oled_vbat_n !== 1'b0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) fail_now("vbat_on_timeout", 32'(n));
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_vdd_n",  32'(oled_vdd_n),       32'd1);
    check("midrst_vbat_n", 32'(oled_vbat_n),      32'd1);
    check("midrst_load",   32'(spi_bus.spi_load), 32'd0);
    check("midrst_busy",   32'(busy),             32'd0);
    check("midrst_res_n",  32'(oled_res_n),       32'd1);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    clear_marks();
    push_sequence();
    applyStimulus_start();
    wait_init_done(20000);
    checkOutput_done("run3");
    check("replay_vdd_first", 32'(vdd_fall >= 0 && ae_cyc >= 0 && vdd_fall < ae_cyc), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
